// File: rtl/cache_axi_rd_arbiter_if.sv
// Bundle of cache-side request/return signals and the AXI4 AR/R channel for the refill read arbiter.
// The arbiter uses the master modport; caches plus the AXI bridge sit on the slave side.
interface cache_axi_rd_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [7:0]        i_rd_len;
    logic              i_rd_rdy;
    logic              i_ret_valid;
    logic              i_ret_last;
    logic [DATA_W-1:0] i_ret_data;
    logic              i_ret_ready;

    logic              d_rd_req;
    logic [ADDR_W-1:0] d_rd_addr;
    logic [7:0]        d_rd_len;
    logic [2:0]        d_rd_size;
    logic              d_rd_rdy;
    logic              d_ret_valid;
    logic              d_ret_last;
    logic [DATA_W-1:0] d_ret_data;
    logic              d_ret_ready;

    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic              rd_err;

    modport master (
        input  i_rd_req, i_rd_addr, i_rd_len, i_ret_ready,
        input  d_rd_req, d_rd_addr, d_rd_len, d_rd_size, d_ret_ready,
        input  arready, rdata, rresp, rlast, rvalid,
        output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
        output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready, rd_err
    );

    modport slave (
        output i_rd_req, i_rd_addr, i_rd_len, i_ret_ready,
        output d_rd_req, d_rd_addr, d_rd_len, d_rd_size, d_ret_ready,
        output arready, rdata, rresp, rlast, rvalid,
        input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
        input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready, rd_err
    );
endinterface

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one single-outstanding AXI4 read channel between I-cache and D-cache refill engines:
// arbitrates requests, issues AR, steers R beats to the winner and flags protocol/response errors.
module cache_axi_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter bit          RR_EN  = 1'b1,
    parameter logic [3:0]  I_ID   = 4'd0,
    parameter logic [3:0]  D_ID   = 4'd1
) (
    input logic                   clk,
    input logic                   rst,
    cache_axi_rd_arbiter_if.master bus
);
    typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_grant_d;
    logic              r_last_d;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [7:0]        r_beat_cnt;
    logic              r_err;

    logic              w_any_req;
    logic              w_pick_d;
    logic              w_sel_ready;
    logic              w_beat_hs;
    logic              w_beat_err;
    logic [DATA_W-1:0] w_rdata;

    assign w_any_req   = bus.i_rd_req || bus.d_rd_req;
    assign w_sel_ready = r_grant_d ? bus.d_ret_ready : bus.i_ret_ready;
    assign w_beat_hs   = (r_state == StR) && bus.rvalid && w_sel_ready;
    assign w_beat_err  = w_beat_hs && ((bus.rresp != 2'b00) ||
                                       (bus.rlast && (r_beat_cnt != r_len)) ||
                                       (!bus.rlast && (r_beat_cnt == r_len)));

    // last_grant resets to I, so D takes the first tie under round-robin
    always_comb begin
        if (bus.i_rd_req && bus.d_rd_req) begin
            w_pick_d = RR_EN ? ~r_last_d : 1'b1;
        end else begin
            w_pick_d = bus.d_rd_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_any_req) w_state_nxt = StAr;
            StAr:    if (bus.arready) w_state_nxt = StR;
            StR:     if (w_beat_hs && bus.rlast) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_d  <= 1'b0;
            r_last_d   <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == StIdle) && w_any_req) begin
                r_grant_d <= w_pick_d;
                r_addr    <= w_pick_d ? bus.d_rd_addr : bus.i_rd_addr;
                r_len     <= w_pick_d ? bus.d_rd_len : bus.i_rd_len;
                r_size    <= w_pick_d ? bus.d_rd_size : 3'd2;
            end
            if ((r_state == StAr) && bus.arready) begin
                r_beat_cnt <= '0;
            end else if (w_beat_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (w_beat_hs && bus.rlast) begin
                r_last_d <= r_grant_d;
            end
            if (w_beat_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_rdata     = bus.rdata;
    assign bus.i_ret_data = w_rdata;
    assign bus.d_ret_data = w_rdata;
    assign bus.arid    = r_grant_d ? D_ID : I_ID;
    assign bus.araddr  = r_addr;
    assign bus.arlen   = r_len;
    assign bus.arsize  = r_size;
    assign bus.arburst = 2'b01;
    assign bus.rd_err  = r_err;

    always_comb begin
        bus.arvalid     = (r_state == StAr);
        bus.rready      = 1'b0;
        bus.i_rd_rdy    = 1'b0;
        bus.d_rd_rdy    = 1'b0;
        bus.i_ret_valid = 1'b0;
        bus.i_ret_last  = 1'b0;
        bus.d_ret_valid = 1'b0;
        bus.d_ret_last  = 1'b0;
        if ((r_state == StAr) && bus.arready) begin
            bus.i_rd_rdy = ~r_grant_d;
            bus.d_rd_rdy = r_grant_d;
        end
        if (r_state == StR) begin
            bus.rready = w_sel_ready;
            if (r_grant_d) begin
                bus.d_ret_valid = bus.rvalid;
                bus.d_ret_last  = bus.rlast;
            end else begin
                bus.i_ret_valid = bus.rvalid;
                bus.i_ret_last  = bus.rlast;
            end
        end
    end
endmodule
